// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response bundle between the core's memory port
// and dmem_responder.
//   req_valid/req_ready : request handshake
//   req_addr/we/size/wdata : byte address, store flag, funct3 size code, store data
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata/rsp_err   : extended load data (0 for stores/errors), error flag
// Modports: master = initiator (core side), slave = responder.
interface dmem_responder_if #(
  parameter int ADDR_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_we;
  logic [2:0]        req_size;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_addr, req_we, req_size, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_size, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder for the load/store
// path. Accepts a request (addr, we, funct3 size), waits LATENCY cycles, then
// commits the store / samples the load on the edge entering RESP and holds the
// response until the consumer takes it.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset (storage contents are not reset)
//   mif    : dmem_responder_if slave modport (request + response channels)
//   busy   : high whenever the FSM is not IDLE
// Parameters: ADDR_W, DEPTH_WORDS (power of two, >=2), LATENCY (>=0).
// Build option: define MISALIGN_TRAP_EN to flag misaligned half/word accesses
// as errors; otherwise the misaligned low address bits are cleared.

// One byte lane of word storage; read is combinational.
module dmem_lane #(
  parameter int DEPTH = 1024,
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata
);
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];
endmodule

module dmem_responder #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_responder_if.slave   mif,
  output logic              busy
);
  localparam int IDX_W     = $clog2(DEPTH_WORDS);
  localparam int AL_W      = IDX_W + 2;
  localparam int CNT_W     = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [AL_W-1:0]   addr_q, addr_d;
  logic              we_q, we_d;
  logic [2:0]        size_q, size_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  // Upper address bits only alias; they never reach storage.
  logic unused_addr_hi;
  assign unused_addr_hi = ^mif.req_addr[ADDR_W-1:AL_W];

  // In IDLE the live request is decoded so a zero-latency access can commit
  // on its accept edge; afterwards the captured copy is used.
  logic              in_idle, accept;
  logic [AL_W-1:0]   eff_addr;
  logic              eff_we;
  logic [2:0]        eff_size;
  logic [31:0]       eff_wdata;

  assign in_idle   = (state_q == IDLE);
  assign accept    = mif.req_valid & in_idle;
  assign eff_addr  = in_idle ? mif.req_addr[AL_W-1:0] : addr_q;
  assign eff_we    = in_idle ? mif.req_we    : we_q;
  assign eff_size  = in_idle ? mif.req_size  : size_q;
  assign eff_wdata = in_idle ? mif.req_wdata : wdata_q;

  // Access decode
  logic                        is_half, is_word, size_ok, misal, acc_err;
  logic [1:0]                  off;
  logic [IDX_W-1:0]            idx;
  logic [NUM_LANES-1:0][7:0]   rd_word, wr_word;
  logic [NUM_LANES-1:0]        be;
  logic [7:0]                  rd_byte;
  logic [15:0]                 rd_half;
  logic [31:0]                 ld_data;
  logic                        enter_resp, mem_we;

  assign is_half = (eff_size[1:0] == 2'b01);
  assign is_word = (eff_size[1:0] == 2'b10);
  assign size_ok = eff_we ? (eff_size inside {3'b000, 3'b001, 3'b010})
                          : (eff_size inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  assign idx     = eff_addr[AL_W-1:2];

`ifdef MISALIGN_TRAP_EN
  assign misal = (is_half & eff_addr[0]) | (is_word & (|eff_addr[1:0]));
  assign off   = eff_addr[1:0];
`else
  assign misal = 1'b0;
  assign off   = {eff_addr[1] & ~is_word, eff_addr[0] & ~is_word & ~is_half};
`endif

  assign acc_err = ~size_ok | misal;

  assign rd_byte = rd_word[off];
  assign rd_half = off[1] ? rd_word[3:2] : rd_word[1:0];

  always_comb begin
    ld_data = '0;
    if (!eff_we && !acc_err) begin
      case (eff_size)
        3'b000:  ld_data = {{24{rd_byte[7]}}, rd_byte};
        3'b001:  ld_data = {{16{rd_half[15]}}, rd_half};
        3'b010:  ld_data = rd_word;
        3'b100:  ld_data = {24'd0, rd_byte};
        3'b101:  ld_data = {16'd0, rd_half};
        default: ld_data = '0;
      endcase
    end
  end

  // Replicate store data across lanes; byte enables pick which lanes commit.
  always_comb begin
    be      = '0;
    wr_word = eff_wdata;
    case (eff_size[1:0])
      2'b00: begin
        be           = 4'b0001 << off;
        wr_word      = {4{eff_wdata[7:0]}};
      end
      2'b01: begin
        be           = off[1] ? 4'b1100 : 4'b0011;
        wr_word      = {2{eff_wdata[15:0]}};
      end
      2'b10:   be    = 4'b1111;
      default: be    = '0;
    endcase
  end

  assign enter_resp = (in_idle & accept & (LATENCY == 0)) |
                      ((state_q == WAIT) & (cnt_q == CNT_W'(1)));
  // rst_n gate keeps a zero-latency accept from committing while in reset.
  assign mem_we     = enter_resp & eff_we & ~acc_err & rst_n;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    dmem_lane #(.DEPTH(DEPTH_WORDS), .IDX_W(IDX_W)) u_lane (
      .clk   (clk),
      .we    (mem_we & be[g]),
      .idx   (idx),
      .wdata (wr_word[g]),
      .rdata (rd_word[g])
    );
  end

  // FSM next state / datapath
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = mif.req_addr[AL_W-1:0];
          we_d    = mif.req_we;
          size_d  = mif.req_size;
          wdata_d = mif.req_wdata;
          cnt_d   = CNT_W'(LATENCY);
          state_d = (LATENCY == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = RESP;
      end
      RESP: begin
        if (mif.rsp_ready) begin
          state_d = IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (enter_resp) begin
      rdata_d = ld_data;
      err_d   = acc_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign mif.req_ready = in_idle;
  assign mif.rsp_valid = (state_q == RESP);
  assign mif.rsp_rdata = rdata_q;
  assign mif.rsp_err   = err_q;
  assign busy          = ~in_idle;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: scoreboard queue of expected responses,
// immediate assertions at each comparison point.
module tb_dmem_responder;
  localparam int ADDR_W  = 32;
  localparam int DEPTH   = 1024;
  localparam int LATENCY = 2;
  localparam int BOUND   = 50;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  dmem_responder_if #(.ADDR_W(ADDR_W)) bif ();

  dmem_responder #(.ADDR_W(ADDR_W), .DEPTH_WORDS(DEPTH), .LATENCY(LATENCY)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mif   (bif),
    .busy  (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full transaction; called just after a negedge. hold = cycles to stall the
  // response while a competing store request is waved at the busy responder.
  task automatic xact(input string tag, input logic [31:0] a, input logic we,
                      input logic [2:0] sz, input logic [31:0] wd,
                      input logic [31:0] er, input logic ee, input int hold);
    int   n;
    exp_t e;
    exp_q.push_back(exp_t'{rdata: er, err: ee});
    bif.req_valid = 1'b1;
    bif.req_addr  = a;
    bif.req_we    = we;
    bif.req_size  = sz;
    bif.req_wdata = wd;
    n = 0;
    while (bif.req_ready !== 1'b1 && n < BOUND) begin @(negedge clk); n++; end
    chk({tag, "/accept"}, 32'(n < BOUND), 32'd1);
    @(negedge clk);
    bif.req_valid = 1'b0;
    bif.req_addr  = $urandom;
    n = 1;
    while (bif.rsp_valid !== 1'b1 && n < BOUND) begin @(negedge clk); n++; end
    chk({tag, "/latency"}, n, LATENCY + 1);
    e = exp_q.pop_front();
    chk({tag, "/rdata"}, bif.rsp_rdata, e.rdata);
    chk({tag, "/err"}, 32'(bif.rsp_err), 32'(e.err));
    for (int i = 0; i < hold; i++) begin
      bif.req_valid = 1'b1;
      bif.req_addr  = 32'h10;
      bif.req_we    = 1'b1;
      bif.req_size  = 3'b010;
      bif.req_wdata = 32'hFFFF_FFFF;
      @(negedge clk);
      chk({tag, "/hold_valid"}, 32'(bif.rsp_valid), 32'd1);
      chk({tag, "/hold_rdata"}, bif.rsp_rdata, e.rdata);
      chk({tag, "/hold_err"}, 32'(bif.rsp_err), 32'(e.err));
      chk({tag, "/hold_rdy"}, 32'(bif.req_ready), 32'd0);
    end
    bif.req_valid = 1'b0;
    bif.rsp_ready = 1'b1;
    @(negedge clk);
    bif.rsp_ready = 1'b0;
    chk({tag, "/done_valid"}, 32'(bif.rsp_valid), 32'd0);
    chk({tag, "/done_rdy"}, 32'(bif.req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n         = 1'b0;
    bif.req_valid = 1'b0;
    bif.req_addr  = '0;
    bif.req_we    = 1'b0;
    bif.req_size  = '0;
    bif.req_wdata = '0;
    bif.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst/req_ready", 32'(bif.req_ready), 32'd1);
    chk("rst/rsp_valid", 32'(bif.rsp_valid), 32'd0);
    chk("rst/rdata", bif.rsp_rdata, 32'd0);
    chk("rst/err", 32'(bif.rsp_err), 32'd0);
    chk("rst/busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // store then load back
    xact("sw10", 32'h10, 1'b1, 3'b010, 32'hDEAD_BEEF, 32'h0, 1'b0, 0);
    xact("lw10", 32'h10, 1'b0, 3'b010, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);
    // byte/half extension
    xact("lb13", 32'h13, 1'b0, 3'b000, 32'h0, 32'hFFFF_FFDE, 1'b0, 0);
    xact("lbu13", 32'h13, 1'b0, 3'b100, 32'h0, 32'h0000_00DE, 1'b0, 0);
    xact("lhu12", 32'h12, 1'b0, 3'b101, 32'h0, 32'h0000_DEAD, 1'b0, 0);
    // lane writes preserve other lanes
    xact("sh12", 32'h12, 1'b1, 3'b001, 32'hFFFF_1234, 32'h0, 1'b0, 0);
    xact("sb10", 32'h10, 1'b1, 3'b000, 32'hFFFF_FF55, 32'h0, 1'b0, 0);
    xact("lw10b", 32'h10, 1'b0, 3'b010, 32'h0, 32'h1234_BE55, 1'b0, 0);
    xact("lh10", 32'h10, 1'b0, 3'b001, 32'h0, 32'hFFFF_BE55, 1'b0, 0);
    xact("lh12", 32'h12, 1'b0, 3'b001, 32'h0, 32'h0000_1234, 1'b0, 0);
    xact("lb10", 32'h10, 1'b0, 3'b000, 32'h0, 32'h0000_0055, 1'b0, 0);
    // index wraps modulo depth, upper bits ignored
    xact("alias", 32'h8000_1010, 1'b0, 3'b010, 32'h0, 32'h1234_BE55, 1'b0, 0);
    // stalled response; competing store must be ignored
    xact("hold", 32'h10, 1'b0, 3'b010, 32'h0, 32'h1234_BE55, 1'b0, 3);
    xact("lw_after_hold", 32'h10, 1'b0, 3'b010, 32'h0, 32'h1234_BE55, 1'b0, 0);
    // misalignment / illegal sizes
`ifdef MISALIGN_TRAP_EN
    xact("lw11", 32'h11, 1'b0, 3'b010, 32'h0, 32'h0, 1'b1, 0);
    xact("lh13", 32'h13, 1'b0, 3'b001, 32'h0, 32'h0, 1'b1, 0);
`else
    xact("lw11", 32'h11, 1'b0, 3'b010, 32'h0, 32'h1234_BE55, 1'b0, 0);
    xact("lh13", 32'h13, 1'b0, 3'b001, 32'h0, 32'h0000_1234, 1'b0, 0);
`endif
    xact("ld011", 32'h10, 1'b0, 3'b011, 32'h0, 32'h0, 1'b1, 0);
    xact("ld110", 32'h10, 1'b0, 3'b110, 32'h0, 32'h0, 1'b1, 0);
    xact("st111", 32'h10, 1'b1, 3'b111, 32'h0BAD_0BAD, 32'h0, 1'b1, 0);
    xact("st100", 32'h10, 1'b1, 3'b100, 32'h0BAD_0BAD, 32'h0, 1'b1, 0);
    xact("lw_untouched", 32'h10, 1'b0, 3'b010, 32'h0, 32'h1234_BE55, 1'b0, 0);

    // reset during WAIT drops a pending store
    xact("sw20", 32'h20, 1'b1, 3'b010, 32'h1122_3344, 32'h0, 1'b0, 0);
    bif.req_valid = 1'b1;
    bif.req_addr  = 32'h20;
    bif.req_we    = 1'b1;
    bif.req_size  = 3'b010;
    bif.req_wdata = 32'hA5A5_A5A5;
    n = 0;
    while (bif.req_ready !== 1'b1 && n < BOUND) begin @(negedge clk); n++; end
    chk("rstw/accept", 32'(n < BOUND), 32'd1);
    @(negedge clk);
    bif.req_valid = 1'b0;
    chk("rstw/busy_wait", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstw/req_ready", 32'(bif.req_ready), 32'd1);
    chk("rstw/rsp_valid", 32'(bif.rsp_valid), 32'd0);
    chk("rstw/busy", 32'(busy), 32'd0);
    chk("rstw/rdata", bif.rsp_rdata, 32'd0);
    chk("rstw/err", 32'(bif.rsp_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xact("lw20", 32'h20, 1'b0, 3'b010, 32'h0, 32'h1122_3344, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
